// File: rtl/jk_excite_driver.sv
// jk_excite_driver: drives the J/K inputs of an external W-bit JK flop bank
// so that the bank moves to a requested target word. Each attempt is one
// APPLY cycle followed by one CHECK cycle that compares the fed-back Q value
// against the target; a failed check re-applies up to MAX_RETRY times before
// reporting err. A clean check reports done.
module jk_excite_driver #(
    parameter int W         = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tgt_valid,
    input  logic [W-1:0] tgt_data,
    input  logic         cfg_toggle,
    output logic         tgt_ready,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         busy,
    output logic         done,
    output logic         err
);

    // Counter must hold the value MAX_RETRY itself; keep at least one bit.
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE   = RW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   target;
    logic           mode;
    logic [RW-1:0]  retry;

    // Excitation for one attempt, returned as {j, k}.
    // Toggle style drives j=k=1 on every bit that must flip; set/reset style
    // drives j to raise a bit and k to clear it, leaving matching bits alone.
    function automatic logic [2*W-1:0] excite(input logic [W-1:0] cur,
                                              input logic [W-1:0] tgt,
                                              input logic         tog);
        logic [W-1:0] diff;
        diff = cur ^ tgt;
        if (tog)
            return {diff, diff};
        else
            return {~cur & tgt, cur & ~tgt};
    endfunction

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Main controller: handshake, apply/check sequencing, retry bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            target <= '0;
            mode   <= 1'b0;
            retry  <= '0;
            j      <= '0;
            k      <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        target <= tgt_data;
                        mode   <= cfg_toggle;
                        retry  <= '0;
                        {j, k} <= excite(q_fb, tgt_data, cfg_toggle);
                        state  <= APPLY;
                    end
                end
                APPLY: begin
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == target) begin
                        done  <= 1'b1;
                        retry <= '0;
                        state <= IDLE;
                    end else if (retry < RETRY_LIMIT) begin
                        retry  <= retry + RETRY_ONE;
                        {j, k} <= excite(q_fb, target, mode);
                        state  <= APPLY;
                    end else begin
                        err   <= 1'b1;
                        retry <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    j     <= '0;
                    k     <= '0;
                    retry <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
